// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared size encodings, FSM states and timeout default for the load/store unit
package lsu_ctrl_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
        return sz == SZ_B || (sz == SZ_H && !a[0]) || (sz == SZ_W && a == 2'b00);
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering and load byte/half extraction with sign or zero extension
module lsu_align import lsu_ctrl_pkg::*; (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        ext_sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] ld_data
);
    logic [31:0] sh;

    // Alignment guarantees a half offset of 0 or 2, so one shifter serves both sizes
    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        be = size == SZ_B ? 4'b0001 << off : size == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        lane_wdata = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
        ld_data = size == SZ_B ? {{24{ext_sign & sh[7]}}, sh[7:0]} :
                  size == SZ_H ? {{16{ext_sign & sh[15]}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller -- alignment check, bus handshake with timeout, pipeline stall
module lsu_ctrl import lsu_ctrl_pkg::*; #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        ext_sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    state_t      state;
    logic [31:0] laddr, lwdata, ld;
    logic [1:0]  lsize;
    logic        lsign, lwe, req, ok, busy;
    logic [3:0]  be;
    logic [CW-1:0] cnt;

    assign req  = mem_read | mem_write;
    assign ok   = is_aligned(mem_size, addr[1:0]);
    assign busy = state == BUSY;

    // Gated by rst_n so a request held during reset cannot raise stall or misalign
    assign stall    = rst_n & (busy | (state == IDLE & req & ok));
    assign misalign = rst_n & state == IDLE & req & !ok;
    assign bus_req  = busy;
    assign bus_we   = busy & lwe;
    assign bus_be   = busy ? be : 4'b0000;
    assign bus_addr = {laddr[31:2], 2'b00};

    lsu_align u_align (
        .size(lsize),
        .off(laddr[1:0]),
        .ext_sign(lsign),
        .wdata(lwdata),
        .rdata(bus_rdata),
        .be(be),
        .lane_wdata(bus_wdata),
        .ld_data(ld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata   <= '0;
            bus_err <= 1'b0;
            laddr   <= '0;
            lwdata  <= '0;
            lsize   <= SZ_B;
            lsign   <= 1'b0;
            lwe     <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: if (req && ok) begin
                    laddr  <= addr;
                    lwdata <= wdata;
                    lsize  <= mem_size;
                    lsign  <= ext_sign;
                    lwe    <= mem_write;
                    cnt    <= '0;
                    state  <= BUSY;
                end
                BUSY: if (bus_ack) begin
                    rdata <= ld;
                    state <= DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    rdata   <= '0;
                    bus_err <= 1'b1;
                    state   <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors for lsu_ctrl with hand-computed expectations
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 0, rst_n = 0, mem_read = 0, mem_write = 0, ext_sign = 0, bus_ack = 0;
    logic [1:0]  mem_size = 0;
    logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
    logic        stall, misalign, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int n_tests = 0, n_fail = 0;
    int stalls, bcnt, errs;
    logic [31:0] d_rdata, c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .ext_sign(ext_sign), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ack_at: BUSY cycle (1-based) on which bus_ack is raised, 0 for never
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rv,
                          input int ack_at);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_size = sz; ext_sign = sg; addr = a; wdata = wd;
        stalls = 0; bcnt = 0; errs = 0; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            errs += int'(bus_err);
            if (!stall) break;
            stalls++;
            if (bus_req) begin
                bcnt++;
                c_addr = bus_addr; c_be = bus_be; c_wdata = bus_wdata; c_we = bus_we;
            end
            bus_ack = bus_req && bcnt == ack_at;
            bus_rdata = rv;
            @(negedge clk);
            bus_ack = 0;
        end
        d_rdata = rdata;
        @(negedge clk);
        #1;
        errs += int'(bus_err);
        check("req_ignored_in_done", {31'b0, bus_req}, 32'd0);
        mem_read = 0; mem_write = 0;
    endtask

    task automatic misal(input string tag, input logic [1:0] sz, input logic [31:0] a);
        int hits;
        int m;
        hits = 0; m = 0;
        @(negedge clk);
        mem_read = 1; mem_size = sz; addr = a;
        for (int c = 0; c < 3; c++) begin
            #1;
            hits += int'(bus_req | stall);
            m += int'(misalign);
            @(negedge clk);
        end
        mem_read = 0;
        check({tag, "_flag"}, m, 3);
        check({tag, "_nobus"}, hits, 0);
    endtask

    initial begin
        #2;
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_bus_req", {31'b0, bus_req}, 0);
        check("rst_bus_we", {31'b0, bus_we}, 0);
        check("rst_bus_be", {28'b0, bus_be}, 0);
        check("rst_bus_err", {31'b0, bus_err}, 0);
        check("rst_misalign", {31'b0, misalign}, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1;

        access(1, 0, SZ_W, 0, 32'h100, 0, 32'hDEADBEEF, 2);
        check("lw_stalls", stalls, 3);
        check("lw_busy", bcnt, 2);
        check("lw_rdata", d_rdata, 32'hDEADBEEF);
        check("lw_addr", c_addr, 32'h100);
        check("lw_be", {28'b0, c_be}, 32'hF);
        check("lw_we", {31'b0, c_we}, 0);
        check("lw_err", errs, 0);

        access(1, 0, SZ_B, 1, 32'h103, 0, 32'h80123456, 1);
        check("lb_rdata", d_rdata, 32'hFFFFFF80);
        check("lb_addr", c_addr, 32'h100);
        check("lb_be", {28'b0, c_be}, 32'h8);
        check("lb_stalls", stalls, 2);
        access(1, 0, SZ_B, 0, 32'h103, 0, 32'h80123456, 1);
        check("lbu_rdata", d_rdata, 32'h00000080);

        access(1, 0, SZ_H, 1, 32'h102, 0, 32'h9ABC1111, 3);
        check("lh_rdata", d_rdata, 32'hFFFF9ABC);
        check("lh_stalls", stalls, 4);
        access(1, 0, SZ_H, 0, 32'h100, 0, 32'h12348001, 1);
        check("lhu_rdata", d_rdata, 32'h00008001);
        check("lhu_be", {28'b0, c_be}, 32'h3);

        access(0, 1, SZ_H, 0, 32'h102, 32'h1234ABCD, 0, 1);
        check("sh_we", {31'b0, c_we}, 1);
        check("sh_be", {28'b0, c_be}, 32'hC);
        check("sh_wdata", c_wdata, 32'hABCDABCD);

        access(0, 1, SZ_B, 0, 32'h101, 32'hAABBCC55, 0, 1);
        check("sb_be", {28'b0, c_be}, 32'h2);
        check("sb_wdata", c_wdata, 32'h55555555);

        access(1, 1, SZ_W, 0, 32'h200, 32'hCAFEF00D, 0, 2);
        check("rw_we", {31'b0, c_we}, 1);
        check("rw_be", {28'b0, c_be}, 32'hF);
        check("rw_wdata", c_wdata, 32'hCAFEF00D);
        check("rw_addr", c_addr, 32'h200);

        misal("mis_word", SZ_W, 32'h101);
        misal("mis_size3", 2'b11, 32'h100);
        misal("mis_half", SZ_H, 32'h101);

        access(1, 0, SZ_W, 0, 32'h104, 0, 32'h13579BDF, 1);
        access(1, 0, SZ_W, 0, 32'h108, 0, 32'hFFFFFFFF, 0);
        check("to_busy", bcnt, 16);
        check("to_stalls", stalls, 17);
        check("to_err_once", errs, 1);
        check("to_rdata", d_rdata, 0);

        access(1, 0, SZ_W, 0, 32'h10C, 0, 32'h2468ACE0, 16);
        check("ackwin_busy", bcnt, 16);
        check("ackwin_err", errs, 0);
        check("ackwin_rdata", d_rdata, 32'h2468ACE0);

        @(negedge clk);
        bus_ack = 1; bus_rdata = 32'h11111111;
        repeat (2) @(negedge clk);
        #1;
        bus_ack = 0;
        check("idle_ack_req", {31'b0, bus_req}, 0);
        check("idle_ack_rdata", rdata, 32'h2468ACE0);

        @(negedge clk);
        mem_read = 1; mem_size = SZ_W; addr = 32'h300;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_req", {31'b0, bus_req}, 1);
        rst_n = 0;
        #1;
        check("mid_rst_req", {31'b0, bus_req}, 0);
        check("mid_rst_stall", {31'b0, stall}, 0);
        check("mid_rst_be", {28'b0, bus_be}, 0);
        check("mid_rst_rdata", rdata, 0);
        mem_read = 0;
        @(negedge clk);
        rst_n = 1;
        access(1, 0, SZ_H, 1, 32'h302, 0, 32'h7FFF0000, 1);
        check("post_rst_rdata", d_rdata, 32'h00007FFF);
        check("post_rst_stalls", stalls, 2);
        check("post_rst_addr", c_addr, 32'h300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
